// File: rtl/uart_msg_framer_pkg.sv
// Shared types and constants for the UART message framer.
// Holds the FSM state encoding, the default inter-word timeout and a width helper.
// The CHECK state exists only when MSG_CHECKSUM_EN is defined.
package uart_msg_framer_pkg;

    // About two UART words at 9600 baud with a 54 MHz core clock
    localparam int DEFAULT_TIMEOUT_CLKS = 112500;

`ifdef MSG_CHECKSUM_EN
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_CHECK   = 2'd2
    } state_t;
`else
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;
`endif

    function automatic int msg_width(input int word_size, input int words);
        return word_size * words;
    endfunction

endpackage

// File: rtl/msg_fifo_fwft.sv
// First-word-fall-through message FIFO: head entry is always visible on head_dat.
// Latency: a push shows on head_vld the cycle after the push edge; pop is immediate.
// Backpressure: a push into a full FIFO without a same-cycle pop is dropped and flagged on drop.
module msg_fifo_fwft #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic             head_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic [LVL_W-1:0] level,
    output logic             drop
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             empty;
    logic             do_pop;
    logic             do_push;

    // A pop frees the head slot in the same cycle, so a full FIFO can still accept a push then
    assign empty    = (level == '0);
    assign full     = (level == LVL_W'(DEPTH));
    assign do_pop   = pop_rdy && !empty;
    assign do_push  = push_vld && (!full || do_pop);
    assign drop     = push_vld && full && !do_pop;
    assign head_vld = !empty;
    assign head_dat = mem[rd_ptr];

    // Storage: cleared on reset so the head reads zero until the first message lands
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally at DEPTH; level tracks occupancy for full/empty
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                level <= level + LVL_W'(1);
            end else if (do_pop && !do_push) begin
                level <= level - LVL_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_msg_framer.sv
// Packs WORDS_PER_PACKET UART words into a message, drops stalled partials, queues messages in a FWFT FIFO.
// Latency: last word strobed at edge N -> msg_valid high after edge N+1 (empty FIFO).
// Backpressure: msg_ready pops the head; complete packets arriving to a full FIFO are dropped (overflow_err).
// Optional trailing checksum word when MSG_CHECKSUM_EN is defined.
module uart_msg_framer
    import uart_msg_framer_pkg::*;
#(
    parameter int WORD_SIZE        = 8,
    parameter int WORDS_PER_PACKET = 4,
    parameter int FIFO_DEPTH       = 8,
    parameter int TIMEOUT_CLKS     = DEFAULT_TIMEOUT_CLKS
) (
    input  logic                                   clk,
    input  logic                                   n_reset,
    input  logic [WORD_SIZE-1:0]                   rx_data,
    input  logic                                   rx_valid,
    output logic [WORD_SIZE*WORDS_PER_PACKET-1:0]  msg_data,
    output logic                                   msg_valid,
    input  logic                                   msg_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]        fifo_level,
    output logic                                   timeout_err,
    output logic                                   overflow_err,
    input  logic                                   err_clear
`ifdef MSG_CHECKSUM_EN
  , output logic                                   checksum_err
`endif
);

    localparam int MSG_W = msg_width(WORD_SIZE, WORDS_PER_PACKET);
    localparam int CNT_W = $clog2(WORDS_PER_PACKET + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   word_cnt;
    logic [CNT_W-1:0]   word_cnt_nxt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [TMO_W-1:0]   tmo_cnt_nxt;
    logic [MSG_W-1:0]   pkt_dat;
    logic               tmo_expired;
    logic               load_word;
    logic               push_nxt;
    logic               push_vld;
    logic               tmo_fire;
    logic               fifo_drop;
`ifdef MSG_CHECKSUM_EN
    logic [WORD_SIZE-1:0] csum;
    logic                 csum_bad;
`endif

    assign tmo_expired = (tmo_cnt == TMO_W'(TIMEOUT_CLKS - 1));

    // Next-state logic: collect words, time out idle partials; a word on the timeout cycle wins
    always_comb begin
        state_nxt    = state;
        word_cnt_nxt = word_cnt;
        tmo_cnt_nxt  = tmo_cnt;
        load_word    = 1'b0;
        push_nxt     = 1'b0;
        tmo_fire     = 1'b0;
`ifdef MSG_CHECKSUM_EN
        csum_bad     = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (rx_valid) begin
                    load_word    = 1'b1;
                    word_cnt_nxt = CNT_W'(1);
                    tmo_cnt_nxt  = '0;
                    state_nxt    = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (rx_valid) begin
                    load_word   = 1'b1;
                    tmo_cnt_nxt = '0;
                    if (word_cnt == CNT_W'(WORDS_PER_PACKET - 1)) begin
`ifdef MSG_CHECKSUM_EN
                        state_nxt = ST_CHECK;
`else
                        push_nxt  = 1'b1;
                        state_nxt = ST_IDLE;
`endif
                    end else begin
                        word_cnt_nxt = word_cnt + CNT_W'(1);
                    end
                end else if (tmo_expired) begin
                    tmo_fire  = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
                end
            end
`ifdef MSG_CHECKSUM_EN
            ST_CHECK: begin
                if (rx_valid) begin
                    tmo_cnt_nxt = '0;
                    push_nxt    = (rx_data == csum);
                    csum_bad    = (rx_data != csum);
                    state_nxt   = ST_IDLE;
                end else if (tmo_expired) begin
                    tmo_fire  = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM, counters and the registered push / timeout strobes
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state       <= ST_IDLE;
            word_cnt    <= '0;
            tmo_cnt     <= '0;
            push_vld    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            word_cnt    <= word_cnt_nxt;
            tmo_cnt     <= tmo_cnt_nxt;
            push_vld    <= push_nxt;
            timeout_err <= tmo_fire;
        end
    end

    // Shift words in from the LS end so the first received word ends up in the MS bits
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            pkt_dat <= '0;
        end else if (load_word) begin
            pkt_dat <= {pkt_dat[MSG_W-WORD_SIZE-1:0], rx_data};
        end
    end

`ifdef MSG_CHECKSUM_EN
    // Running modular sum of payload words, restarted by the first word of each packet
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            csum <= '0;
        end else if (load_word) begin
            csum <= (state == ST_IDLE) ? rx_data : csum + rx_data;
        end
    end

    // Sticky checksum error; a new mismatch beats a simultaneous clear
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            checksum_err <= 1'b0;
        end else if (csum_bad) begin
            checksum_err <= 1'b1;
        end else if (err_clear) begin
            checksum_err <= 1'b0;
        end
    end
`endif

    // Sticky overflow error; a new drop beats a simultaneous clear
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            overflow_err <= 1'b0;
        end else if (fifo_drop) begin
            overflow_err <= 1'b1;
        end else if (err_clear) begin
            overflow_err <= 1'b0;
        end
    end

    msg_fifo_fwft #(
        .WIDTH (MSG_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .n_reset  (n_reset),
        .push_vld (push_vld),
        .push_dat (pkt_dat),
        .pop_rdy  (msg_ready),
        .head_vld (msg_valid),
        .head_dat (msg_data),
        .level    (fifo_level),
        .drop     (fifo_drop)
    );

endmodule
